// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg
//  Purpose  : Shared encodings for the RV32I execute stage: ALU operations,
//             forwarding selects, branch conditions and writeback sources.
//  Revision : 1.0  initial release
// ============================================================================
package rv32_pkg;

    // ALU operation codes carried in id_ex_alu_ctrl
    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_AND   = 4'd2;
    localparam logic [3:0] c_ALU_OR    = 4'd3;
    localparam logic [3:0] c_ALU_XOR   = 4'd4;
    localparam logic [3:0] c_ALU_SLT   = 4'd5;
    localparam logic [3:0] c_ALU_SLTU  = 4'd6;
    localparam logic [3:0] c_ALU_SLL   = 4'd7;
    localparam logic [3:0] c_ALU_SRL   = 4'd8;
    localparam logic [3:0] c_ALU_SRA   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // Operand forwarding selects (2'b11 behaves like the register file)
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    // Branch conditions (funct3)
    localparam logic [2:0] c_BR_EQ     = 3'b000;
    localparam logic [2:0] c_BR_NE     = 3'b001;
    localparam logic [2:0] c_BR_LT     = 3'b100;
    localparam logic [2:0] c_BR_GE     = 3'b101;
    localparam logic [2:0] c_BR_LTU    = 3'b110;
    localparam logic [2:0] c_BR_GEU    = 3'b111;

    // Writeback result source
    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_MEM  = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : rv_alu
//  Purpose  : Purely combinational RV32I ALU. Results wrap modulo 2^XLEN;
//             shift amount is taken from the low bits of operand B.
//  Revision : 1.0  initial release
// ============================================================================
module rv_alu
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_result
);

    localparam int c_SHW = $clog2(XLEN);

    logic [c_SHW-1:0] w_shamt;
    assign w_shamt = i_b[c_SHW-1:0];

    // Operation select; undefined codes yield zero
    always_comb begin
        o_result = '0;
        case (i_op)
            c_ALU_ADD:   o_result = i_a + i_b;
            c_ALU_SUB:   o_result = i_a - i_b;
            c_ALU_AND:   o_result = i_a & i_b;
            c_ALU_OR:    o_result = i_a | i_b;
            c_ALU_XOR:   o_result = i_a ^ i_b;
            c_ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            c_ALU_SLL:   o_result = i_a << w_shamt;
            c_ALU_SRL:   o_result = i_a >> w_shamt;
            c_ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            c_ALU_PASSB: o_result = i_b;
            default:     o_result = '0;
        endcase
    end

endmodule : rv_alu
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : RV32I execute stage. Forwards operands, runs the ALU, resolves
//             branches/jumps (zero-latency redirect) and registers results
//             into the EX/MEM pipeline register with stall/flush handling.
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_ex_valid,
    input  logic [XLEN-1:0] id_ex_rd1,
    input  logic [XLEN-1:0] id_ex_rd2,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_pc4,
    input  logic [4:0]      id_ex_rd,
    input  logic [3:0]      id_ex_alu_ctrl,
    input  logic            id_ex_alusrc,
    input  logic            id_ex_branch,
    input  logic [2:0]      id_ex_funct3,
    input  logic            id_ex_jump,
    input  logic            id_ex_jalr,
    input  logic            id_ex_regwrite,
    input  logic            id_ex_memwrite,
    input  logic [1:0]      id_ex_resultsrc,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] mem_wb_result,
    output logic            pcsrc_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            ex_mem_valid,
    output logic            ex_mem_regwrite,
    output logic            ex_mem_memwrite,
    output logic [1:0]      ex_mem_resultsrc,
    output logic [4:0]      ex_mem_rd,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_wdata,
    output logic [XLEN-1:0] ex_mem_pc4
);

    logic            r_valid;
    logic            r_regwrite;
    logic            r_memwrite;
    logic [1:0]      r_resultsrc;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc4;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_taken;

    // Operand forwarding: EX/MEM source is the registered ALU result
    always_comb begin
        w_src_a = id_ex_rd1;
        w_fwd_b = id_ex_rd2;
        case (forwardAE)
            FWD_EXMEM: w_src_a = r_alu_result;
            FWD_MEMWB: w_src_a = mem_wb_result;
            default:   w_src_a = id_ex_rd1;
        endcase
        case (forwardBE)
            FWD_EXMEM: w_fwd_b = r_alu_result;
            FWD_MEMWB: w_fwd_b = mem_wb_result;
            default:   w_fwd_b = id_ex_rd2;
        endcase
    end

    assign w_src_b = id_ex_alusrc ? id_ex_imm : w_fwd_b;

    rv_alu #(
        .XLEN     (XLEN)
    ) u_alu (
        .i_a      (w_src_a),
        .i_b      (w_src_b),
        .i_op     (id_ex_alu_ctrl),
        .o_result (w_alu_result)
    );

    // Branch condition on forwarded operands; reserved funct3 never taken
    always_comb begin
        w_taken = 1'b0;
        case (id_ex_funct3)
            c_BR_EQ:  w_taken = (w_src_a == w_fwd_b);
            c_BR_NE:  w_taken = (w_src_a != w_fwd_b);
            c_BR_LT:  w_taken = ($signed(w_src_a) <  $signed(w_fwd_b));
            c_BR_GE:  w_taken = ($signed(w_src_a) >= $signed(w_fwd_b));
            c_BR_LTU: w_taken = (w_src_a <  w_fwd_b);
            c_BR_GEU: w_taken = (w_src_a >= w_fwd_b);
            default:  w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum  = w_src_a + id_ex_imm;
    assign pc_target_o = id_ex_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (id_ex_pc + id_ex_imm);

    // A stalled EX must not redirect: the instruction will be re-presented
    assign pcsrc_o = id_ex_valid & ~stall_i & ~rst &
                     (id_ex_jump | id_ex_jalr | (id_ex_branch & w_taken));

    // EX/MEM register: reset > stall (hold) > flush (bubble) > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_resultsrc  <= 2'b00;
            r_rd         <= 5'd0;
            r_alu_result <= '0;
            r_wdata      <= '0;
            r_pc4        <= '0;
        end else if (!stall_i) begin
            // Data fields load even on flush; they are meaningless once valid is low
            r_resultsrc  <= id_ex_resultsrc;
            r_rd         <= id_ex_rd;
            r_alu_result <= w_alu_result;
            r_wdata      <= w_fwd_b;
            r_pc4        <= id_ex_pc4;
            if (flush_i) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                r_valid    <= id_ex_valid;
                r_regwrite <= id_ex_valid & id_ex_regwrite;
                r_memwrite <= id_ex_valid & id_ex_memwrite;
            end
        end
    end

    assign ex_mem_valid      = r_valid;
    assign ex_mem_regwrite   = r_regwrite;
    assign ex_mem_memwrite   = r_memwrite;
    assign ex_mem_resultsrc  = r_resultsrc;
    assign ex_mem_rd         = r_rd;
    assign ex_mem_alu_result = r_alu_result;
    assign ex_mem_wdata      = r_wdata;
    assign ex_mem_pc4        = r_pc4;

endmodule : ex_stage
`default_nettype wire
